// File: rtl/alu_host_pkg.sv
// Shared definitions for the UART ALU host: operation encoding, opcode bytes,
// framing constants and the TX state encoding.
package alu_host_pkg;

    typedef enum logic [1:0] {
        ALU_ECHO = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_DIV  = 2'd3
    } alu_op_t;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hAF;
    localparam logic [7:0] OP_DIV  = 8'hF6;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_DATA = 3'd3,
        ST_WAIT = 3'd4
    } tx_state_t;

    // First byte of every packet.
    function automatic logic [7:0] op_byte(alu_op_t op);
        case (op)
            ALU_ECHO: op_byte = OP_ECHO;
            ALU_ADD:  op_byte = OP_ADD;
            ALU_MUL:  op_byte = OP_MUL;
            default:  op_byte = OP_DIV;
        endcase
    endfunction

endpackage

// File: rtl/alu_host_rx_assembler.sv
// Reply side of the ALU host: packs RX bytes little-endian into 32-bit words,
// tracks how many reply bytes are still expected, flags the final word and
// backpressures the UART while a finished word is waiting to be taken.
// Optional port 'outstanding' exists only with ALU_HOST_TIMEOUT_EN defined.
module alu_host_rx_assembler
    import alu_host_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    input  alu_op_t            op,
    input  logic [COUNT_W-1:0] count,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_data,
    output logic               res_last,
    output logic               done
`ifdef ALU_HOST_TIMEOUT_EN
    ,
    output logic               outstanding
`endif
);

    localparam int REM_W = COUNT_W + 2;

    logic [REM_W-1:0] remaining;
    logic [1:0]       byte_k;
    logic [23:0]      partial;
    logic             done_flag;
    logic             take;
    logic             hand;

    // A held word blocks the UART; a byte may still enter in the cycle the word leaves.
    assign rx_ready = !res_valid || res_ready;
    // Bytes with nothing outstanding (idle, or surplus) are consumed and dropped.
    assign take     = rx_valid && rx_ready && (remaining != '0);
    assign hand     = res_valid && res_ready;
    // The last word may be handed off before TX reaches WAIT, so remember it.
    assign done     = done_flag || (hand && res_last);

`ifdef ALU_HOST_TIMEOUT_EN
    assign outstanding = (remaining != '0);
`endif

    // Byte packing, remaining-reply counter and result word hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            byte_k    <= '0;
            partial   <= '0;
            done_flag <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
        end else if (clear) begin
            remaining <= '0;
            byte_k    <= '0;
            partial   <= '0;
            done_flag <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
        end else begin
            if (start) begin
                remaining <= (op == ALU_ECHO) ? {count, 2'b00} : REM_W'(WORD_BYTES);
                byte_k    <= '0;
                done_flag <= 1'b0;
            end
            if (hand) begin
                res_valid <= 1'b0;
                res_last  <= 1'b0;
                if (res_last) begin
                    done_flag <= 1'b1;
                end
            end
            if (take) begin
                remaining <= remaining - 1'b1;
                byte_k    <= byte_k + 2'd1;
                case (byte_k)
                    2'd0: partial[7:0]   <= rx_data;
                    2'd1: partial[15:8]  <= rx_data;
                    2'd2: partial[23:16] <= rx_data;
                    default: begin
                        res_valid <= 1'b1;
                        res_data  <= {rx_data, partial};
                        res_last  <= (remaining == REM_W'(1));
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_host.sv
// Host-side initiator for the UART ALU protocol. Frames a command as
// opcode, 0x00, LEN[7:0], LEN[15:8], then payload words LSB first, and
// returns the device reply as 32-bit words through alu_host_rx_assembler.
// Optional reply timeout: define ALU_HOST_TIMEOUT_EN.
module alu_host
    import alu_host_pkg::*;
#(
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [COUNT_W-1:0] cmd_count_i,
    input  logic               opnd_valid_i,
    output logic               opnd_ready_o,
    input  logic [31:0]        opnd_data_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    input  logic               tx_ready_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_valid_i,
    output logic               rx_ready_o,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [31:0]        res_data_o,
    output logic               res_last_o,
    output logic               busy_o,
    output logic               error_o,
    output logic               timeout_o
);

    localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);
    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);

    tx_state_t          state;
    tx_state_t          state_next;
    logic [1:0]         byte_idx;
    logic [COUNT_W-1:0] words_left;
    logic [31:0]        shreg;
    logic [15:0]        len;
    logic [7:0]         hdr_next;
    logic               cmd_acc;
    logic               start;
    logic               tx_hs;
    logic               rx_done;
    logic               timeout_hit;

    assign cmd_acc = cmd_valid_i && cmd_ready_o;
    assign start   = cmd_acc && (cmd_count_i != '0);
    assign tx_hs   = tx_valid_o && tx_ready_i;
    // words_left still holds the full count while the header is going out.
    assign len     = 16'(HDR_BYTES) + 16'(words_left) * 16'(WORD_BYTES);

    // Header byte that follows the one currently on the TX port.
    always_comb begin
        hdr_next = 8'h00;
        case (byte_idx)
            2'd1:    hdr_next = len[7:0];
            2'd2:    hdr_next = len[15:8];
            default: hdr_next = 8'h00;
        endcase
    end

    // TX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_HDR;
            ST_HDR:  if (tx_hs && byte_idx == HDR_LAST) state_next = ST_LOAD;
            ST_LOAD: if (opnd_valid_i) state_next = ST_DATA;
            ST_DATA: begin
                if (tx_hs && byte_idx == WORD_LAST) begin
                    state_next = (words_left == COUNT_W'(1)) ? ST_WAIT : ST_LOAD;
                end
            end
            ST_WAIT: if (rx_done || timeout_hit) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the TX state.
    always_comb begin
        cmd_ready_o  = 1'b0;
        opnd_ready_o = 1'b0;
        case (state)
            ST_IDLE: cmd_ready_o  = 1'b1;
            ST_LOAD: opnd_ready_o = 1'b1;
            default: ;
        endcase
    end

    // Byte serializer: tx_valid_o/tx_data_o only move on a handshake or a new load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            shreg      <= '0;
            busy_o     <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            error_o <= cmd_acc && (cmd_count_i == '0);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        words_left <= cmd_count_i;
                        byte_idx   <= '0;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= op_byte(alu_op_t'(cmd_op_i));
                        busy_o     <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (tx_hs) begin
                        if (byte_idx == HDR_LAST) begin
                            tx_valid_o <= 1'b0;
                            byte_idx   <= '0;
                        end else begin
                            byte_idx  <= byte_idx + 2'd1;
                            tx_data_o <= hdr_next;
                        end
                    end
                end
                ST_LOAD: begin
                    if (opnd_valid_i) begin
                        shreg      <= opnd_data_i;
                        tx_data_o  <= opnd_data_i[7:0];
                        tx_valid_o <= 1'b1;
                        byte_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (tx_hs) begin
                        if (byte_idx == WORD_LAST) begin
                            tx_valid_o <= 1'b0;
                            byte_idx   <= '0;
                            words_left <= words_left - 1'b1;
                        end else begin
                            byte_idx  <= byte_idx + 2'd1;
                            shreg     <= shreg >> 8;
                            tx_data_o <= shreg[15:8];
                        end
                    end
                end
                ST_WAIT: begin
                    if (rx_done || timeout_hit) begin
                        busy_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_HOST_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        outstanding;
    logic        rx_byte_acc;

    assign rx_byte_acc = rx_valid_i && rx_ready_o;
    assign timeout_hit = (state == ST_WAIT) && outstanding &&
                         (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Reply watchdog: runs only in WAIT with bytes outstanding, restarts on every RX byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt   <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_hit;
            if (state != ST_WAIT || rx_byte_acc || timeout_hit) begin
                tmo_cnt <= '0;
            end else if (outstanding) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    // No watchdog in this build; false for every legal TIMEOUT_CYCLES.
    assign timeout_o   = (TIMEOUT_CYCLES < 0);
`endif

    alu_host_rx_assembler #(
        .COUNT_W (COUNT_W)
    ) u_rx (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .start       (start),
        .clear       (timeout_hit),
        .op          (alu_op_t'(cmd_op_i)),
        .count       (cmd_count_i),
        .rx_data     (rx_data_i),
        .rx_valid    (rx_valid_i),
        .rx_ready    (rx_ready_o),
        .res_valid   (res_valid_o),
        .res_ready   (res_ready_i),
        .res_data    (res_data_o),
        .res_last    (res_last_o),
        .done        (rx_done)
`ifdef ALU_HOST_TIMEOUT_EN
        ,
        .outstanding (outstanding)
`endif
    );

endmodule

// File: tb/tb_alu_host.sv
// Directed bench for alu_host: ADD, MUL with TX stalls, ECHO with result
// backpressure, zero-count rejection, async reset mid-packet, and the
// no-reply case (timeout when ALU_HOST_TIMEOUT_EN is defined).
module tb_alu_host;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [7:0]  cmd_count_i;
    logic        opnd_valid_i;
    logic        opnd_ready_o;
    logic [31:0] opnd_data_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        res_last_o;
    logic        busy_o;
    logic        error_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    alu_host #(
        .COUNT_W        (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_count_i  (cmd_count_i),
        .opnd_valid_i (opnd_valid_i),
        .opnd_ready_o (opnd_ready_o),
        .opnd_data_i  (opnd_data_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_last_o   (res_last_o),
        .busy_o       (busy_o),
        .error_o      (error_o),
        .timeout_o    (timeout_o)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  txlog[$];
    logic [7:0]  rxq[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] opq[$];
    logic [31:0] reslog[$];
    logic        lastlog[$];
    logic        cmd_req    = 1'b0;
    logic        echo_mode  = 1'b0;
    logic        res_rdy_en = 1'b1;
    logic        tx_stall   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, then log the handshakes
    // that the next rising edge will complete.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        cmd_valid_i  = cmd_req;
        opnd_valid_i = (opq.size() > 0);
        opnd_data_i  = opnd_valid_i ? opq[0] : 32'h0;
        rx_valid_i   = (rxq.size() > 0);
        rx_data_i    = rx_valid_i ? rxq[0] : 8'h00;
        res_ready_i  = res_rdy_en;
        tx_ready_i   = tx_stall ? cyc[0] : 1'b1;
        #1;
        if (prev_stall) begin
            check("tx_hold_valid", 32'(tx_valid_o), 32'd1);
            check("tx_hold_data", 32'(tx_data_o), 32'(prev_byte));
        end
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_byte  = tx_data_o;
        if (cmd_valid_i && cmd_ready_o) cmd_req = 1'b0;
        if (opnd_valid_i && opnd_ready_o) void'(opq.pop_front());
        if (rx_valid_i && rx_ready_o) void'(rxq.pop_front());
        if (tx_valid_o && tx_ready_i) begin
            txlog.push_back(tx_data_o);
            if (echo_mode && txlog.size() > 4) rxq.push_back(tx_data_o);
        end
        if (res_valid_o && res_ready_i) begin
            reslog.push_back(res_data_o);
            lastlog.push_back(res_last_o);
        end
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && txlog.size() < n; i++) cycle();
        check(tag, 32'(txlog.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy_o; i++) cycle();
        check(tag, 32'(busy_o), 32'd0);
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_len"}, 32'(txlog.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < txlog.size()) ? 32'(txlog[i]) : 32'h100, 32'(exp_tx[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        check({tag, "_rx_ready"}, 32'(rx_ready_o), 32'd1);
        check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_opnd_ready"}, 32'(opnd_ready_o), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
        check({tag, "_res_data"}, res_data_o, 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    task automatic clear_logs();
        txlog.delete();
        rxq.delete();
        reslog.delete();
        lastlog.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        int   k;
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_count_i = 8'd0;
        opnd_valid_i = 1'b0; opnd_data_i = 32'h0;
        tx_ready_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; res_ready_i = 1'b1;

        // Reset state
        repeat (2) cycle();
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        cycle();

        // ADD 5 + 7
        clear_logs();
        opq.push_back(32'd5); opq.push_back(32'd7);
        cmd_op_i = 2'd1; cmd_count_i = 8'd2; cmd_req = 1'b1;
        cycle();
        cycle();
        check("add_first_valid", 32'(tx_valid_o), 32'd1);
        check("add_first_byte", 32'(tx_data_o), 32'hAD);
        check("add_busy", 32'(busy_o), 32'd1);
        check("add_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
        wait_tx(12, 200, "add_tx_count");
        rxq.push_back(8'h0C); rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h00);
        wait_idle(200, "add_idle");
        exp_tx = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                   8'h07, 8'h00, 8'h00, 8'h00};
        check_tx("add_tx");
        check("add_res_count", 32'(reslog.size()), 32'd1);
        check("add_res_data", (reslog.size() > 0) ? reslog[0] : 32'hDEADBEEF, 32'h0000000C);
        check("add_res_last", (lastlog.size() > 0) ? 32'(lastlog[0]) : 32'h2, 32'd1);
        check("add_cmd_ready_after", 32'(cmd_ready_o), 32'd1);

        // MUL 0xFFFFFFFD * 4 with TX stalling every other cycle
        clear_logs();
        tx_stall = 1'b1;
        opq.push_back(32'hFFFFFFFD); opq.push_back(32'd4);
        cmd_op_i = 2'd2; cmd_count_i = 8'd2; cmd_req = 1'b1;
        wait_tx(12, 400, "mul_tx_count");
        tx_stall = 1'b0;
        rxq.push_back(8'hF4); rxq.push_back(8'hFF); rxq.push_back(8'hFF); rxq.push_back(8'hFF);
        wait_idle(200, "mul_idle");
        exp_tx = '{8'hAF, 8'h00, 8'h0C, 8'h00, 8'hFD, 8'hFF, 8'hFF, 8'hFF,
                   8'h04, 8'h00, 8'h00, 8'h00};
        check_tx("mul_tx");
        check("mul_res_data", (reslog.size() > 0) ? reslog[0] : 32'hDEADBEEF, 32'hFFFFFFF4);
        check("mul_res_last", (lastlog.size() > 0) ? 32'(lastlog[0]) : 32'h2, 32'd1);

        // ECHO with the first result word held for 20 cycles
        clear_logs();
        echo_mode = 1'b1; res_rdy_en = 1'b0;
        opq.push_back(32'h11223344); opq.push_back(32'hAABBCCDD);
        cmd_op_i = 2'd0; cmd_count_i = 8'd2; cmd_req = 1'b1;
        for (int i = 0; i < 200 && !res_valid_o; i++) cycle();
        check("echo_w0_valid", 32'(res_valid_o), 32'd1);
        check("echo_w0_data", res_data_o, 32'h11223344);
        check("echo_w0_last", 32'(res_last_o), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("echo_hold_rx_ready", 32'(rx_ready_o), 32'd0);
            check("echo_hold_data", res_data_o, 32'h11223344);
        end
        res_rdy_en = 1'b1;
        wait_idle(300, "echo_idle");
        echo_mode = 1'b0;
        exp_tx = '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                   8'hDD, 8'hCC, 8'hBB, 8'hAA};
        check_tx("echo_tx");
        check("echo_res_count", 32'(reslog.size()), 32'd2);
        check("echo_res0", (reslog.size() > 0) ? reslog[0] : 32'hDEADBEEF, 32'h11223344);
        check("echo_res1", (reslog.size() > 1) ? reslog[1] : 32'hDEADBEEF, 32'hAABBCCDD);
        check("echo_last0", (lastlog.size() > 0) ? 32'(lastlog[0]) : 32'h2, 32'd0);
        check("echo_last1", (lastlog.size() > 1) ? 32'(lastlog[1]) : 32'h2, 32'd1);

        // Zero-count command is rejected
        clear_logs();
        cmd_op_i = 2'd1; cmd_count_i = 8'd0; cmd_req = 1'b1;
        cycle();
        cycle();
        check("zero_error_pulse", 32'(error_o), 32'd1);
        check("zero_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("zero_busy", 32'(busy_o), 32'd0);
        cycle();
        check("zero_error_end", 32'(error_o), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (tx_valid_o) saw = 1'b1;
        end
        check("zero_no_tx", 32'(saw), 32'd0);
        check("zero_txlog", 32'(txlog.size()), 32'd0);

        // Asynchronous reset during the 6th TX byte
        clear_logs();
        opq.push_back(32'h01020304); opq.push_back(32'h05060708);
        cmd_op_i = 2'd1; cmd_count_i = 8'd2; cmd_req = 1'b1;
        wait_tx(6, 100, "rst_reach6");
        check("rst_byte6", 32'(tx_data_o), 32'h03);
        #2 rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        opq.delete();
        repeat (2) cycle();
        clear_logs();
        rst_ni = 1'b1;
        cycle();

        // DIV after reset starts with a fresh header
        opq.push_back(32'h64); opq.push_back(32'h05);
        cmd_op_i = 2'd3; cmd_count_i = 8'd2; cmd_req = 1'b1;
        wait_tx(12, 200, "div_tx_count");
        rxq.push_back(8'h14); rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h00);
        wait_idle(200, "div_idle");
        exp_tx = '{8'hF6, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
                   8'h05, 8'h00, 8'h00, 8'h00};
        check_tx("div_tx");
        check("div_res_data", (reslog.size() > 0) ? reslog[0] : 32'hDEADBEEF, 32'h00000014);

        // ADD with no reply
        clear_logs();
        opq.push_back(32'd9);
        cmd_op_i = 2'd1; cmd_count_i = 8'd1; cmd_req = 1'b1;
        wait_tx(8, 100, "noreply_tx_count");
`ifdef ALU_HOST_TIMEOUT_EN
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            cycle();
            if (timeout_o) begin
                k = i;
                break;
            end
        end
        check("tmo_cycle", 32'(k), 32'd101);
        check("tmo_busy", 32'(busy_o), 32'd0);
        check("tmo_res_valid", 32'(res_valid_o), 32'd0);
        cycle();
        check("tmo_pulse_end", 32'(timeout_o), 32'd0);
        check("tmo_cmd_ready", 32'(cmd_ready_o), 32'd1);
`else
        k = 0;
        saw = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (!busy_o) k++;
            if (timeout_o) saw = 1'b1;
        end
        check("noreply_busy_held", 32'(k), 32'd0);
        check("noreply_no_timeout", 32'(saw), 32'd0);
        rst_ni = 1'b0;
        opq.delete();
        repeat (2) cycle();
        rst_ni = 1'b1;
        cycle();
        check("noreply_recover_idle", 32'(cmd_ready_o), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_host.md
Name: alu_host

Overview:
- Host-side initiator for the UART ALU command protocol: turns a command (opcode plus a stream of 32-bit operands) into the framed byte stream the ALU device expects.
- Collects the device's reply bytes and returns them as 32-bit result words.
- Sits between a test or controller core and the UART byte interface, driving the UART TX stream and consuming the RX stream.
- Used to build FPGA-side loopback and self-test of the ALU.

Parameters:
- COUNT_W, 8: width of the operand-count field. Legal range 1..13, so the packet length always fits 16 bits.
- TIMEOUT_CYCLES, 1000000: reply timeout in clocks. Used only when ALU_HOST_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_op_i  in  2  operation, alu_op_t: ECHO, ADD, MUL, DIV.
- cmd_count_i  in  COUNT_W  number of 32-bit payload words.
- opnd_valid_i  in  1  operand word offered.
- opnd_ready_o  out  1  operand word accepted.
- opnd_data_i  in  32  operand word.
- tx_data_o  out  8  byte to UART TX.
- tx_valid_o  out  1  TX byte valid.
- tx_ready_i  in  1  UART TX ready.
- rx_data_i  in  8  byte from UART RX.
- rx_valid_i  in  1  RX byte valid.
- rx_ready_o  out  1  RX byte consumed.
- res_valid_o  out  1  result word valid.
- res_ready_i  in  1  result word consumed.
- res_data_o  out  32  result word, assembled little-endian.
- res_last_o  out  1  final result word of the command.
- busy_o  out  1  command in progress.
- error_o  out  1  one-cycle pulse when a command with cmd_count_i==0 is rejected.
- timeout_o  out  1  one-cycle pulse when a reply times out.

Behaviour:
- Reset: all outputs are 0, except rx_ready_o=1 and cmd_ready_o=1. FSM goes to IDLE and all counters clear.
- Reset is asynchronous. Asserting it mid-command abandons the command with no flush; the next command starts with a fresh header.
- Packet bytes, in order:
  - opcode: ECHO=0xEC, ADD=0xAD, MUL=0xAF, DIV=0xF6;
  - 0x00;
  - LEN[7:0];
  - LEN[15:8];
  - payload words, each sent LSB byte first.
- LEN = 4 + 4*count, computed as a 16-bit value.
- Expected reply byte count: 4 for ADD, MUL and DIV; 4*count for ECHO.
- TX FSM states:
  - IDLE: cmd_ready_o=1. On accept, latch op and count, set busy_o, go to HDR.
  - HDR: send 4 header bytes using byte index 0..3, then go to LOAD.
  - LOAD: opnd_ready_o=1 for one beat. The accepted word goes into the shift register. Go to DATA.
  - DATA: send 4 bytes. Decrement the word count. Go to LOAD if words remain, else WAIT.
  - WAIT: TX finished. Go to IDLE when the RX side reports done.
- tx_valid_o is registered. tx_data_o and tx_valid_o stay stable while tx_valid_o=1 and tx_ready_i=0.
- The first header byte is valid in the cycle after command accept.
- RX side:
  - Runs concurrently with TX, because ECHO replies arrive interleaved with transmission.
  - Assembles bytes into a word. Byte k goes to bits [8k+7:8k].
  - res_valid_o rises the cycle after the 4th byte arrives. res_last_o is set when the remaining reply byte count reaches 0.
  - While res_valid_o=1 and res_ready_i=0, rx_ready_o=0 (backpressure). A new byte may be accepted in the same cycle the held word is consumed.
  - Bytes arriving while the block is IDLE are consumed and discarded.
- Command done: TX in WAIT, and the last result word has been handed off (res_valid_o & res_ready_i & res_last_o). busy_o falls, and cmd_ready_o=1 in the next cycle.
- cmd_count_i==0: the command is accepted, error_o pulses in the next cycle, nothing is transmitted, and the FSM stays IDLE.
- Device semantics are not checked: result values are passed through as received.

Optional Feature:
- Macro: ALU_HOST_TIMEOUT_EN.
- Defined:
  - A counter clears on each accepted RX byte and on entry to WAIT.
  - It counts only while in WAIT with reply bytes still outstanding.
  - When it reaches TIMEOUT_CYCLES: timeout_o pulses for 1 cycle, the RX assembler clears, no res_valid_o is raised, and the FSM goes to IDLE.
- Not defined: timeout_o is tied to 0, there is no counter logic, and the block waits indefinitely.

Decomposition:
- Shared config_pkg gains:
  - alu_op_t enum;
  - opcode byte constants OP_ECHO=0xEC, OP_ADD=0xAD, OP_MUL=0xAF, OP_DIV=0xF6;
  - HDR_BYTES=4 and WORD_BYTES=4.
- One sub-module: alu_host_rx_assembler. It handles byte-to-word packing, the remaining-reply counter, res_last_o generation and backpressure.
- The TX FSM and byte serializer stay in alu_host.

Test Plan:
- ADD, count=2, operands 5 and 7: TX emits AD 00 0C 00 05 00 00 00 07 00 00 00. Device model replies 0C 00 00 00. Expect res_data_o=0x0000000C with res_last_o=1, and busy_o low afterwards.
- MUL, count=2, operands 0xFFFFFFFD and 4: TX emits AF 00 0C 00 FD FF FF FF 04 00 00 00. Reply F4 FF FF FF gives res_data_o=0xFFFFFFF4.
- ECHO, count=2, words 0x11223344 and 0xAABBCCDD: TX emits EC 00 0C 00 44 33 22 11 DD CC BB AA while echoed bytes arrive interleaved.
  - Expect two result words; res_last_o is set only on the second.
  - Hold res_ready_i=0 for 20 cycles after the first word: rx_ready_o stays 0, and no byte is lost.
- count=0 with op=ADD: error_o is high for exactly 1 cycle, tx_valid_o never rises, and cmd_ready_o=1 on the following cycle.
- Drop rst_ni during the 6th TX byte, asynchronously: outputs go to their reset values before the next edge. A subsequent DIV, count=2 (0x64, 0x05) emits F6 00 0C 00 64 00 00 00 05 00 00 00 from the first byte.
- With ALU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=100: ADD with no reply gives timeout_o at the 100th WAIT cycle, then IDLE. With the macro undefined, busy_o stays 1 for at least 1000 cycles.
